pc16: RTL
=========

# pc16

Hack CPU program counter: a 16-bit register holding the address of the next instruction, with priority-ordered clear, load (jump) and increment controls. It sits between the CPU's jump logic and instruction-memory address port. It is built from the team's gate-level 16-bit primitives and adds a halt detector for the Hack end-of-program idiom, a jump to the current address.

## Interface
Parameters:
- WIDTH, 16, counter and address width; only 16 is supported.
- RESET_ADDR, 16'h0000, value of `out` after async reset or `clr`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear to RESET_ADDR; highest priority.
- load  input  1  load `in` into counter (jump taken).
- inc  input  1  increment counter by 1.
- in  input  16  jump target address.
- out  output  16  current program counter.
- halted  output  1  jump-to-self detected; sticky until reset/clr.
- wrapped  output  1  one-cycle pulse, increment rolled FFFF->0000.

## Operation
- Priority per rising edge: clr > load > inc > hold.
- `clr`: out <= RESET_ADDR; halted <= 0; wrapped <= 0.
- `load` with no `clr`: out <= in. If in == out at that edge, halted <= 1. Otherwise halted keeps its value.
- `inc` with no `clr`/`load`: out <= out + 1, modulo 2^16.
  - If out == 16'hFFFF, the next out is 16'h0000 and wrapped is 1 for exactly the following cycle.
- Neither control asserted: out and halted hold; wrapped <= 0.
- While halted == 1, load/inc still act normally; halted only informs the CPU/testbench. It clears only on reset or clr.
- Arithmetic: unsigned 16-bit, carry out of bit 15 discarded except for generating `wrapped`.
- `wrapped` is registered, never combinational. It is 0 on any cycle whose preceding edge was not an FFFF increment.
- Unknown/X on `in` is only sampled when load is the winning control.

## Timing
- Async reset: out = RESET_ADDR, halted = 0, wrapped = 0 immediately on reset assertion; holds while reset is high.
- Reset release: the first edge with reset low applies normal priority.
- Latency: one cycle from control sample to `out` update. `out`, `halted` and `wrapped` are all register outputs with no combinational input-to-output paths.
- Simultaneous load+inc: load wins, with no increment of the loaded value.
- Simultaneous clr+load with in == out: clr wins, and halted stays 0.
- Reset asserted mid-operation overrides everything asynchronously. No partial update is visible.
- Halt compare uses the pre-edge `out`, not the next value.

## Structure
- Shared package `hack_pkg`: WORD_W = 16, PC_RESET = 16'h0000, and typedef `word_t` (16-bit logic).
- Sub-module `inc16`: 16-bit ripple incrementer built from half adders. It outputs the sum plus a carry used for `wrapped`.
- Next-state selection uses the existing 16-bit mux and bitwise primitives. The equality compare for halt is XOR per bit, then a NOR-reduce.
- State is held in a register16 with async reset (out), plus two 1-bit flops (halted, wrapped).

## Test plan
- Reset: assert reset mid-count at out = 0x0005 -> out = 0x0000, halted = 0, wrapped = 0 within the same cycle, before any clock edge.
- Increment run: inc = 1 for 4 cycles from 0x0000 -> out sequence 0x0001, 0x0002, 0x0003, 0x0004.
- Wrap: load 0xFFFE, then inc ×2 -> out 0xFFFF then 0x0000, with wrapped = 1 only in the cycle out = 0x0000.
- Priority: load = 1, inc = 1, in = 0x1234 -> out = 0x1234. Next cycle clr = 1, load = 1, in = 0xBEEF -> out = 0x0000.
- Halt: out = 0x0010, load with in = 0x0010 -> out stays 0x0010, halted = 1. Then inc -> out = 0x0011 with halted still 1. Then clr -> halted = 0.
- Hold: all controls low for 3 cycles at out = 0x00AA -> out unchanged, wrapped = 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: word width, program-counter reset address,
// the 16-bit word type and the 16-bit 2:1 mux primitive used for datapath
// selection.
package hack_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t PC_RESET = 16'h0000;

  // 16-bit 2:1 mux primitive: returns b when sel is high, a otherwise.
  function automatic word_t mux16(input word_t a, input word_t b, input logic sel);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/inc16.sv
// 16-bit ripple incrementer built from a chain of half adders.
// Ports:
//   i_a     - operand
//   o_sum   - i_a + 1, modulo 2^16
//   o_carry - carry out of bit 15 (high only when i_a == 16'hFFFF)
module inc16
  import hack_pkg::*;
(
  input  word_t i_a,
  output word_t o_sum,
  output logic  o_carry
);

  logic [WORD_W:0] w_c;

  // Incrementing is adding a constant 1, which enters as the carry into bit 0.
  assign w_c[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < WORD_W; g++) begin : g_ha
      assign o_sum[g]  = i_a[g] ^ w_c[g];
      assign w_c[g+1]  = i_a[g] & w_c[g];
    end
  endgenerate

  assign o_carry = w_c[WORD_W];

endmodule

// File: rtl/pc16.sv
// Hack CPU program counter with halt (jump-to-self) detection and a
// wrap pulse for FFFF->0000 increments.
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-high reset
//   clr     - synchronous clear to RESET_ADDR (highest priority)
//   load    - load in (jump taken)
//   inc     - increment by one
//   in      - jump target
//   out     - current program counter (registered)
//   halted  - sticky jump-to-self flag, cleared by reset/clr (registered)
//   wrapped - one-cycle pulse after an FFFF increment (registered)
module pc16
  import hack_pkg::*;
#(
  parameter int               WIDTH      = WORD_W,
  parameter logic [WIDTH-1:0] RESET_ADDR = PC_RESET
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             halted,
  output logic             wrapped
);

  word_t r_out;
  logic  r_halted;
  logic  r_wrapped;

  word_t w_inc_sum;
  logic  w_inc_carry;
  word_t w_next;
  logic  w_eq;
  logic  w_halt_next;
  logic  w_wrap_next;

  inc16 u_inc16 (
    .i_a     (r_out),
    .o_sum   (w_inc_sum),
    .o_carry (w_inc_carry)
  );

  // Mux chain ordered so the outermost stage has highest priority:
  // clr > load > inc > hold.
  assign w_next = mux16(mux16(mux16(r_out, w_inc_sum, inc), in, load), RESET_ADDR, clr);

  // Halt compare is against the pre-edge out: XOR per bit, then NOR-reduce.
  assign w_eq = ~|(r_out ^ in);

  assign w_halt_next = ~clr & (r_halted | (load & w_eq));

  // Only a winning increment from FFFF produces the pulse.
  assign w_wrap_next = ~clr & ~load & inc & w_inc_carry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out     <= RESET_ADDR;
      r_halted  <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_out     <= w_next;
      r_halted  <= w_halt_next;
      r_wrapped <= w_wrap_next;
    end
  end

  assign out     = r_out;
  assign halted  = r_halted;
  assign wrapped = r_wrapped;

endmodule
